// File: rtl/shiftright_seq_32b_if.sv
// Request/result bundle for the sequential right shifter.
// master issues requests; slave is the shifter itself.
interface shiftright_seq_32b_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             arith;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output data_in,
    output shamt,
    output arith,
    input  data_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    input  shamt,
    input  arith,
    output data_out,
    output busy,
    output done
  );
endinterface

// File: rtl/shiftright_seq_32b.sv
// Bit-serial right shifter: one bit per cycle, logical or arithmetic.
// Result register only changes when the operation completes.
module shiftright_seq_32b #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic                  clk,
  input logic                  reset,
  shiftright_seq_32b_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] result;
  logic [SHW-1:0]   cnt;
  logic             mode;
  logic [WIDTH-1:0] work_sh;

  // Sign fill only in arithmetic mode.
  assign work_sh = {mode & work[WIDTH-1],
                    work[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            work <= bus.data_in;
            cnt  <= bus.shamt;
            mode <= bus.arith;
            if (bus.shamt == '0) begin
              state  <= DONE;
              result <= bus.data_in;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_sh;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= DONE;
            result <= work_sh;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = result;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_shiftright_seq_32b.sv
// Directed and random checks for shiftright_seq_32b.
// Expected results come from hand values and a shift reference.
module tb_shiftright_seq_32b;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  shiftright_seq_32b_if #(.WIDTH(32), .SHW(5)) bus ();

  shiftright_seq_32b #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  int done_cnt = 0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  int t0 = 0;
  int d0 = 0;
  int prev_t0 = 0;
  int prev_s = 0;
  logic [31:0] last = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] d,
                          input logic [4:0] s,
                          input logic a);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.shamt   = s;
    bus.arith   = a;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    // Scramble operands: the op in flight must ignore them.
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom);
    bus.arith   = 1'($urandom);
    t0 = cyc;
    check("busy_acc", 32'(bus.busy), 32'd1);
    if (s != 5'd0) check("hold", bus.data_out, last);
  endtask

  task automatic finish_op(input string tag,
                           input logic [31:0] exp,
                           input int s,
                           input bit poke);
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(cyc - t0 + 1), 32'(s + 1));
    check({tag, "_data"}, bus.data_out, exp);
    last = exp;
    if (poke) begin
      bus.start   = 1'b1;
      bus.data_in = 32'hDEAD_BEEF;
      bus.shamt   = 5'd0;
      bus.arith   = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    if (poke) check({tag, "_poke_data"}, bus.data_out, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] es;
    logic [31:0] el;
    logic signed [31:0] sd;
    logic [4:0] s;
    logic a;

    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    bus.arith   = 1'b0;
    reset       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data", bus.data_out, 32'd0);
    reset = 1'b0;

    // First edge after reset release accepts start.
    start_op(32'h0000_0004, 5'd2, 1'b0);
    finish_op("r029", 32'h0000_0001, 2, 1'b0);

    start_op(32'h8000_0000, 5'd4, 1'b1);
    finish_op("r030a", 32'hF800_0000, 4, 1'b0);
    start_op(32'h8000_0000, 5'd4, 1'b0);
    finish_op("r030l", 32'h0800_0000, 4, 1'b0);

    start_op(32'h0000_0022, 5'd0, 1'b0);
    finish_op("r031z", 32'h0000_0022, 0, 1'b0);
    start_op(32'hFFFF_FFFF, 5'd31, 1'b0);
    finish_op("r031m", 32'h0000_0001, 31, 1'b0);

    // Start during DONE must be ignored.
    start_op(32'h0000_0100, 5'd1, 1'b0);
    finish_op("r021", 32'h0000_0080, 1, 1'b1);

    // Second start mid-shift is ignored.
    start_op(32'hF0F0_0000, 5'd8, 1'b1);
    d0 = done_cnt;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.start   = 1'b1;
    bus.data_in = 32'h1234_5678;
    bus.shamt   = 5'd1;
    bus.arith   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_op("r032", 32'hFFF0_F000, 8, 1'b0);
    check("r032_one_done", 32'(done_cnt - d0), 32'd1);

    // Abort by reset three cycles into a long op.
    start_op(32'hABCD_0000, 5'd10, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("r033_busy", 32'(bus.busy), 32'd0);
    check("r033_data", bus.data_out, 32'd0);
    check("r033_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("r033_no_done", 32'(done_cnt - d0), 32'd0);
    last = '0;
    start_op(32'h0000_004C, 5'd2, 1'b0);
    finish_op("r033_new", 32'h0000_0013, 2, 1'b0);

    // Random vectors, issued back to back.
    for (int i = 0; i < 1000; i++) begin
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      a  = 1'($urandom_range(0, 1));
      sd = d;
      es = sd >>> s;
      el = d >> s;
      e  = a ? es : el;
      start_op(d, s, a);
      if (i > 0) check("spacing", 32'(t0 - prev_t0), 32'(prev_s + 2));
      prev_t0 = t0;
      prev_s  = int'(s);
      finish_op("rnd", e, int'(s), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shiftright_seq_32b.md
SHIFTRIGHT_SEQ_32B -- requirements
Module: shiftright_seq_32b

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 Parameter: SHW, default 5, shift-amount width; the block SHALL support shamt values 0..WIDTH-1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; SHALL be sampled only in IDLE.
REQ-006 data_in  input  WIDTH  operand; SHALL be captured on the accepted start edge.
REQ-007 shamt  input  SHW  right-shift amount; SHALL be captured on the accepted start edge.
REQ-008 arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); SHALL be captured on the accepted start edge.
REQ-009 data_out  output  WIDTH  result register; SHALL hold its value until the next accepted start.
REQ-010 busy  output  1  high in SHIFT and DONE states.
REQ-011 done  output  1  one-cycle result-valid strobe.

Function
REQ-012 The block SHALL implement a 3-state FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 SHALL load the work register with data_in, the counter with shamt and the mode with arith.
  - The next state SHALL be DONE if shamt==0, otherwise SHIFT.
REQ-014 IDLE with start=0 SHALL hold all state.
REQ-015 Each SHIFT cycle SHALL shift the work register right by exactly 1 bit and decrement the counter by 1.
  - The MSB fill SHALL be the current MSB when mode=1 and 0 when mode=0.
REQ-016 SHIFT SHALL transition to DONE on the cycle the counter decrements from 1 to 0.
REQ-017 DONE SHALL assert done=1 for exactly one cycle with data_out equal to the final result, then return to IDLE.
REQ-018 data_out SHALL be updated only when entering DONE; intermediate shift values SHALL NOT appear on data_out.
REQ-019 Latency: done SHALL assert exactly shamt+1 cycles after the clock edge that accepts start.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on state, counter or result.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new request is accepted in IDLE only.
REQ-022 Changes on data_in, shamt or arith after acceptance SHALL NOT affect the operation in progress.
REQ-023 The result SHALL equal data_in >> shamt (logical) or data_in >>> shamt (arithmetic), truncated to WIDTH bits.
REQ-024 Back-to-back throughput: the minimum start-to-start spacing SHALL be shamt+2 cycles.

Reset
REQ-025 reset=1 at a rising edge SHALL force state=IDLE, data_out=0, busy=0, done=0, counter=0, mode=0 and work register=0.
REQ-026 reset SHALL take priority over start and over any state transition in the same cycle.
REQ-027 reset asserted during SHIFT or DONE SHALL abort the operation.
  - No done pulse SHALL follow the abort.
  - data_out SHALL read 0.
REQ-028 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-029 data_in=32'h0000_0004, shamt=2, arith=0 -> done 3 cycles after start, data_out=32'h0000_0001.
REQ-030 data_in=32'h8000_0000, shamt=4: arith=1 -> 32'hF800_0000; arith=0 -> 32'h0800_0000; both with done 5 cycles after start.
REQ-031 shamt=0, data_in=32'h0000_0022 -> done 1 cycle after start, data_out=32'h0000_0022; shamt=31, data_in=32'hFFFF_FFFF, arith=0 -> data_out=32'h0000_0001 after 32 cycles.
REQ-032 Second start pulsed mid-SHIFT with different operands -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-033 reset asserted 3 cycles into a shamt=10 operation -> busy=0 and data_out=0 next cycle, no done pulse; a fresh start with data_in=32'h0000_004C, shamt=2 then yields 32'h0000_0013.
REQ-034 Random self-check: at least 1000 random data_in/shamt/arith vectors compared against the REQ-023 reference, with latency checked per REQ-019.
